bus_bridge_initiator_frame_engine: RTL

Bus-B side of the UART bus bridge. It takes the byte stream recovered by the Bus-B UART receiver and assembles 4-byte request frames. Each frame is replayed as one transaction on a Bus-B initiator port, and one response byte goes back to the Bus-B UART transmitter. It consumes exactly what the Bus-A bridge target wrapper serialises onto its UART TX line.

---
 rtl/bus_bridge_pkg.sv | 38 +++
 rtl/bridge_frame_assembler.sv | 105 ++++++++++
 rtl/bus_bridge_initiator_frame_engine.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// bus_bridge_pkg
// Shared definitions for both sides of the UART bus bridge.
//   FRAME_BYTES       request frame length on the UART link (CMD, ADDR_HI,
//                     ADDR_LO, DATA)
//   CMD_* positions   layout of the CMD byte (bit 0 = write, 7:1 ignored)
//   DEFAULT_ACK_BYTE  response byte for a completed write; also recognised by
//                     the Bus-A wrapper's response decoder
//   bridge_state_e    state encoding of the Bus-B initiator frame engine
//   bridge_frame_t    one latched request frame
// -----------------------------------------------------------------------------
package bus_bridge_pkg;

  localparam int FRAME_BYTES     = 4;
  localparam int BYTE_IDX_W      = $clog2(FRAME_BYTES);

  localparam int CMD_RW_BIT      = 0;
  localparam int CMD_IGNORED_MSB = 7;
  localparam int CMD_IGNORED_LSB = 1;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAC;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_REQ     = 3'd1,
    ST_XFER    = 3'd2,
    ST_RDATA   = 3'd3,
    ST_SPLIT   = 3'd4,
    ST_RESP    = 3'd5
  } bridge_state_e;

  typedef struct packed {
    logic        rw;    // 1 = write, 0 = read
    logic [15:0] addr;  // Bus-B absolute address
    logic [7:0]  data;  // write data (don't-care for reads)
  } bridge_frame_t;

endpackage

// File: rtl/bridge_frame_assembler.sv
// -----------------------------------------------------------------------------
// bridge_frame_assembler
// Counts incoming UART bytes while the engine is collecting and latches a
// complete request frame on the 4th byte.
//
// Optional feature: `BRIDGE_FRAME_TIMEOUT_EN enables an inter-byte gap counter
// that discards a partial frame after TIMEOUT_CYCLES idle cycles. Without the
// macro a partial frame waits indefinitely.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_byte      byte from the UART receiver
//   rx_valid     one-cycle strobe qualifying rx_byte
//   collect_en   engine is in COLLECT; bytes outside it are not counted
//   frame_done   combinational: this cycle's byte completes a frame
//   frame        last latched frame (valid from the cycle after frame_done)
//   byte_count   bytes collected so far for the current frame (debug)
// -----------------------------------------------------------------------------
module bridge_frame_assembler
  import bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  input  logic                  collect_en,
  output logic                  frame_done,
  output bridge_frame_t         frame,
  output logic [BYTE_IDX_W-1:0] byte_count
);

  logic [BYTE_IDX_W-1:0] count_q;
  logic                  cmd_rw_q;
  logic [7:0]            addr_hi_q;
  logic [7:0]            addr_lo_q;
  logic                  accept;
  logic                  timeout_fire;

  assign accept     = collect_en && rx_valid;
  assign frame_done = accept && (count_q == BYTE_IDX_W'(FRAME_BYTES - 1));
  assign byte_count = count_q;

  // A byte always wins over a simultaneous timeout: timeout_fire is masked by
  // rx_valid, so the 4th byte in a timeout cycle still completes the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= frame_done ? '0 : count_q + 1'b1;
    end else if (timeout_fire) begin
      count_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rw_q  <= 1'b0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
    end else if (accept) begin
      case (count_q)
        BYTE_IDX_W'(0): cmd_rw_q  <= rx_byte[CMD_RW_BIT];
        BYTE_IDX_W'(1): addr_hi_q <= rx_byte;
        BYTE_IDX_W'(2): addr_lo_q <= rx_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
    end else if (frame_done) begin
      frame.rw   <= cmd_rw_q;
      frame.addr <= {addr_hi_q, addr_lo_q};
      frame.data <= rx_byte;
    end
  end

`ifdef BRIDGE_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;

  // Counts idle cycles of a partial frame; fires on the TIMEOUT_CYCLES-th one.
  assign timeout_fire = collect_en && (count_q != '0) && !rx_valid &&
                        (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (!collect_en || (count_q == '0) || rx_valid || timeout_fire) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_fire       = 1'b0;
`endif

endmodule

// File: rtl/bus_bridge_initiator_frame_engine.sv
// -----------------------------------------------------------------------------
// bus_bridge_initiator_frame_engine
// Bus-B side of the UART bus bridge. Assembles 4-byte request frames
// (CMD, ADDR_HI, ADDR_LO, DATA) from the UART receiver, replays each as one
// Bus-B initiator transaction and returns one response byte to the UART
// transmitter (ACK_BYTE for writes, read data for reads).
//
// Optional feature: `BRIDGE_FRAME_TIMEOUT_EN (partial-frame gap timeout, see
// bridge_frame_assembler).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_byte, rx_valid          UART receiver byte + one-cycle strobe
//   tx_byte, tx_valid, tx_ready response byte to the UART transmitter
//   init_req / init_grant      bus request / grant
//   init_addr_out(_valid)      Bus-B address
//   init_data_out(_valid)      write data (valid only for writes)
//   init_rw                    1 = write, 0 = read
//   init_ready                 engine idle (COLLECT)
//   init_ack, init_split_ack   target acknowledge / split
//   init_data_in(_valid)       read data
//   overrun                    sticky: byte arrived while busy (reset clears)
//   state_dbg                  current FSM state
//
// Handshake: tx_byte transfers on a cycle where tx_valid && tx_ready; once
// tx_valid rises, tx_byte is held stable and tx_valid stays high until that
// transfer happens.
// -----------------------------------------------------------------------------
module bus_bridge_initiator_frame_engine
  import bus_bridge_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  output logic [7:0]    tx_byte,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          init_req,
  input  logic          init_grant,
  output logic [15:0]   init_addr_out,
  output logic          init_addr_out_valid,
  output logic [7:0]    init_data_out,
  output logic          init_data_out_valid,
  output logic          init_rw,
  output logic          init_ready,
  input  logic          init_ack,
  input  logic          init_split_ack,
  input  logic [7:0]    init_data_in,
  input  logic          init_data_in_valid,
  output logic          overrun,
  output bridge_state_e state_dbg
);

  bridge_state_e         state_q, state_d;
  logic [7:0]            resp_q, resp_d;
  logic                  overrun_q;
  logic                  frame_done;
  bridge_frame_t         frame;
  logic [BYTE_IDX_W-1:0] byte_count;
  logic                  unused_byte_count;

  bridge_frame_assembler #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .collect_en (state_q == ST_COLLECT),
    .frame_done (frame_done),
    .frame      (frame),
    .byte_count (byte_count)
  );

  assign unused_byte_count = ^byte_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
    end
  end

  // Bytes are only consumed in COLLECT; anything else is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (rx_valid && (state_q != ST_COLLECT)) begin
      overrun_q <= 1'b1;
    end
  end

  always_comb begin
    state_d             = state_q;
    resp_d              = resp_q;
    init_req            = 1'b0;
    init_addr_out       = '0;
    init_addr_out_valid = 1'b0;
    init_data_out       = '0;
    init_data_out_valid = 1'b0;
    init_rw             = 1'b0;
    init_ready          = 1'b0;
    tx_valid            = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        init_ready = 1'b1;
        if (frame_done) state_d = ST_REQ;
      end

      ST_REQ: begin
        init_req = 1'b1;
        if (init_grant) state_d = ST_XFER;
      end

      ST_XFER: begin
        init_req            = 1'b1;
        init_addr_out       = frame.addr;
        init_addr_out_valid = 1'b1;
        init_rw             = frame.rw;
        init_data_out       = frame.data;
        init_data_out_valid = frame.rw;
        // A plain ack takes priority over a simultaneous split.
        if (init_ack) begin
          if (frame.rw) begin
            resp_d  = ACK_BYTE;
            state_d = ST_RESP;
          end else if (init_data_in_valid) begin
            resp_d  = init_data_in;
            state_d = ST_RESP;
          end else begin
            state_d = ST_RDATA;
          end
        end else if (init_split_ack) begin
          state_d = ST_SPLIT;
        end
      end

      ST_RDATA: begin
        if (init_data_in_valid) begin
          resp_d  = init_data_in;
          state_d = ST_RESP;
        end
      end

      // Bus released; the target completes the split transaction on its own.
      ST_SPLIT: begin
        if (!frame.rw && init_data_in_valid) begin
          resp_d  = init_data_in;
          state_d = ST_RESP;
        end else if (frame.rw && init_ack) begin
          resp_d  = ACK_BYTE;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        tx_valid = 1'b1;
        if (tx_ready) state_d = ST_COLLECT;
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  assign tx_byte   = resp_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule
